// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   WORD_W            : instruction / address width (16)
//   word_t            : one instruction word or byte address
//   DEFAULT_RESET_PC  : PC loaded on reset
//   DEFAULT_NOP_INSTR : instruction presented to decode whenever valid=0
//   fetch_state_t     : REQ / HOLD / DRAIN / HALTED
//   pc_inc()          : PC + 2, wrapping modulo 2^16
package fetch_stage_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC  = 16'h0000;
  localparam word_t DEFAULT_NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,  // request outstanding
    ST_HOLD   = 2'd1,  // response parked in skid buffer, decode stalled
    ST_DRAIN  = 2'd2,  // waiting out a response that will be discarded
    ST_HALTED = 2'd3   // fetch stopped until reset
  } fetch_state_t;

  // 16-bit add naturally wraps 16'hFFFE -> 16'h0000.
  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(2);
  endfunction

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding an instruction and its PC+2.
// Catches a memory response that arrives while decode is stalled so the
// request does not have to be repeated.
// Ports:
//   clk, rst (async, active-low)
//   load                    : capture load_instr / load_pc_plus2, set full
//   clear                   : drop the entry (load wins if both asserted)
//   load_instr, load_pc_plus2 : entry to capture
//   full                    : entry present
//   instr, pc_plus2         : stored entry
module fetch_skid_buf
  import fetch_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] load_instr,
  input  logic [WORD_W-1:0] load_pc_plus2,
  output logic              full,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc_plus2
);

  logic  full_reg;
  word_t instr_reg;
  word_t pc_plus2_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_reg     <= 1'b0;
      instr_reg    <= NOP_INSTR;
      pc_plus2_reg <= '0;
    end else if (load) begin
      full_reg     <= 1'b1;
      instr_reg    <= load_instr;
      pc_plus2_reg <= load_pc_plus2;
    end else if (clear) begin
      full_reg     <= 1'b0;
    end
  end

  assign full     = full_reg;
  assign instr    = instr_reg;
  assign pc_plus2 = pc_plus2_reg;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch + IF/ID pipeline register.
// Owns the PC, drives a variable-latency instruction memory and presents
// instr/valid/pc_plus2 to decode. Handles hazard stall, execute redirect and halt.
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : odd redirect_pc raises sticky err and halts fetch
//   undefined : redirect_pc bit0 is forced to 0, err tied low
// Ports:
//   clk, rst (async, active-low)
//   stall               : hold IF/ID and PC
//   redirect/redirect_pc: flush and refetch from redirect_pc
//   halt                : stop fetching (left only by reset)
//   imem_req/imem_addr  : memory request, held until imem_done
//   imem_done/imem_rdata: memory response
//   instr/valid/pc_plus2: IF/ID register to decode
//   err                 : misaligned redirect (feature build only)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = DEFAULT_RESET_PC,
  parameter word_t NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_done,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              valid,
  output logic [WORD_W-1:0] pc_plus2,
  output logic              err
);

  fetch_state_t state_reg, state_next;
  word_t        pc_reg, pc_next;
  word_t        instr_reg, instr_next;
  logic         valid_reg, valid_next;
  word_t        pc_plus2_reg, pc_plus2_next;
  word_t        drain_addr_reg, drain_addr_next;   // address of the discarded request
  logic         halt_pend_reg, halt_pend_next;     // DRAIN ends in HALTED, not REQ

  logic  req_phase;
  word_t pc_inc_val;
  logic  skid_load, skid_clear, skid_full;
  word_t skid_instr, skid_pc_plus2;
  logic  misaligned;
  word_t redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_reg;

  assign misaligned      = redirect_pc[0];
  assign redirect_target = redirect_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (redirect && misaligned && state_reg != ST_HALTED) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign misaligned      = 1'b0;
  assign redirect_target = redirect_pc & 16'hFFFE;
  assign err             = 1'b0;
`endif

  assign pc_inc_val = pc_inc(pc_reg);
  assign req_phase  = (state_reg == ST_REQ) || (state_reg == ST_DRAIN);

  // Request is forced low while reset is held even though state resets to REQ.
  assign imem_req   = req_phase & rst;
  // DRAIN keeps presenting the abandoned address until its response lands.
  assign imem_addr  = (state_reg == ST_DRAIN) ? drain_addr_reg : pc_reg;

  fetch_skid_buf #(
    .NOP_INSTR(NOP_INSTR)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_load),
    .clear        (skid_clear),
    .load_instr   (imem_rdata),
    .load_pc_plus2(pc_inc_val),
    .full         (skid_full),
    .instr        (skid_instr),
    .pc_plus2     (skid_pc_plus2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_REQ;
      pc_reg         <= RESET_PC;
      instr_reg      <= NOP_INSTR;
      valid_reg      <= 1'b0;
      pc_plus2_reg   <= pc_inc(RESET_PC);
      drain_addr_reg <= RESET_PC;
      halt_pend_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      valid_reg      <= valid_next;
      pc_plus2_reg   <= pc_plus2_next;
      drain_addr_reg <= drain_addr_next;
      halt_pend_reg  <= halt_pend_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    valid_next      = valid_reg;
    pc_plus2_next   = pc_plus2_reg;
    drain_addr_next = drain_addr_reg;
    halt_pend_next  = halt_pend_reg;
    skid_load       = 1'b0;
    skid_clear      = 1'b0;

    if (state_reg == ST_HALTED) begin
      valid_next = 1'b0;
      instr_next = NOP_INSTR;
    end else if (redirect) begin
      // Redirect outranks stall and halt: flush IF/ID and the skid entry.
      valid_next     = 1'b0;
      instr_next     = NOP_INSTR;
      skid_clear     = 1'b1;
      halt_pend_next = 1'b0;
      if (misaligned) begin
        state_next = ST_HALTED;
      end else begin
        pc_next = redirect_target;
        if (req_phase && !imem_done) begin
          state_next = ST_DRAIN;
          if (state_reg == ST_REQ) begin
            drain_addr_next = pc_reg;
          end
        end else begin
          state_next = ST_REQ;
        end
      end
    end else if (halt) begin
      valid_next = 1'b0;
      instr_next = NOP_INSTR;
      skid_clear = 1'b1;
      if (req_phase && !imem_done) begin
        // Let the outstanding request finish, then stop.
        state_next     = ST_DRAIN;
        halt_pend_next = 1'b1;
        if (state_reg == ST_REQ) begin
          drain_addr_next = pc_reg;
        end
      end else begin
        state_next = ST_HALTED;
      end
    end else begin
      case (state_reg)
        ST_REQ: begin
          if (imem_done) begin
            pc_next = pc_inc_val;
            if (stall) begin
              skid_load  = 1'b1;
              state_next = ST_HOLD;
            end else begin
              instr_next    = imem_rdata;
              valid_next    = 1'b1;
              pc_plus2_next = pc_inc_val;
            end
          end else if (!stall) begin
            // Decode consumed the previous entry; insert a bubble.
            valid_next = 1'b0;
            instr_next = NOP_INSTR;
          end
        end
        ST_HOLD: begin
          if (!stall && skid_full) begin
            instr_next    = skid_instr;
            pc_plus2_next = skid_pc_plus2;
            valid_next    = 1'b1;
            skid_clear    = 1'b1;
            state_next    = ST_REQ;
          end
        end
        ST_DRAIN: begin
          valid_next = 1'b0;
          instr_next = NOP_INSTR;
          if (imem_done) begin
            state_next     = halt_pend_reg ? ST_HALTED : ST_REQ;
            halt_pend_next = 1'b0;
          end
        end
        default: begin
          state_next = ST_HALTED;
        end
      endcase
    end
  end

  assign instr    = instr_reg;
  assign valid    = valid_reg;
  assign pc_plus2 = pc_plus2_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural instruction memory with
// programmable latency, and a scoreboard of expected IF/ID entries that is
// popped each time decode would consume one (valid=1, stall=0).
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic        valid;
  logic [15:0] pc_plus2;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  int   lat = 1;
  int   mem_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_done  (imem_done),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .valid      (valid),
    .pc_plus2   (pc_plus2),
    .err        (err)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Memory: responds on the lat-th consecutive cycle of an asserted request.
  always @(negedge clk) begin
    if (!rst || !imem_req) begin
      mem_cnt    = 0;
      imem_done  = 1'b0;
      imem_rdata = 16'hDEAD;
    end else if (mem_cnt >= lat - 1) begin
      imem_done  = 1'b1;
      imem_rdata = mem_word(imem_addr);
      mem_cnt    = 0;
    end else begin
      imem_done  = 1'b0;
      imem_rdata = 16'hDEAD;
      mem_cnt++;
    end
  end

  // Decode-side consumer / scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (!valid) begin
        check("nop_when_invalid", instr, NOP);
      end else if (!stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr", 16'(exp_q.size()), 16'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", instr, e.instr);
          check("sb_pc_plus2", pc_plus2, e.pc_plus2);
          $display("consumed instr=%h pc_plus2=%h", instr, pc_plus2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a);
    exp_q.push_back('{instr: mem_word(a), pc_plus2: a + 16'd2});
  endtask

  task automatic release_rst();
    rst = 1'b1;
    #1;
  endtask

  task automatic end_test(input string tag);
    check(tag, 16'(exp_q.size()), 16'd0);
    exp_q.delete();
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_imem_req", 16'(imem_req), 16'd0);
    check("rst_valid", 16'(valid), 16'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc_plus2", pc_plus2, 16'h0002);
    check("rst_err", 16'(err), 16'd0);

    // Single-cycle memory, no stall: 0,2,4 back-to-back
    lat = 1;
    push(16'h0000); push(16'h0002); push(16'h0004);
    release_rst();
    check("t1_req", 16'(imem_req), 16'd1);
    check("t1_addr0", imem_addr, 16'h0000);
    tick();
    check("t1_valid1", 16'(valid), 16'd1);
    check("t1_addr2", imem_addr, 16'h0002);
    tick();
    check("t1_valid2", 16'(valid), 16'd1);
    tick();
    check("t1_valid3", 16'(valid), 16'd1);
    check("t1_instr3", instr, mem_word(16'h0004));
    tick();
    end_test("t1_drained");

    // Three-cycle latency: request held at the same address
    lat = 3;
    push(16'h0000); push(16'h0002);
    release_rst();
    check("t2_req_c0", 16'(imem_req), 16'd1);
    check("t2_addr_c0", imem_addr, 16'h0000);
    tick();
    check("t2_req_c1", 16'(imem_req), 16'd1);
    check("t2_addr_c1", imem_addr, 16'h0000);
    check("t2_novalid_c1", 16'(valid), 16'd0);
    tick();
    check("t2_addr_c2", imem_addr, 16'h0000);
    tick();
    check("t2_valid", 16'(valid), 16'd1);
    check("t2_instr", instr, mem_word(16'h0000));
    check("t2_addr_next", imem_addr, 16'h0002);
    repeat (4) tick();
    end_test("t2_drained");

    // Stall while a response arrives: skid buffer keeps it
    lat = 1;
    push(16'h0000); push(16'h0002); push(16'h0004);
    release_rst();
    tick();
    stall = 1'b1;
    tick();
    check("t3_hold_req", 16'(imem_req), 16'd0);
    check("t3_hold_valid", 16'(valid), 16'd1);
    check("t3_hold_instr", instr, mem_word(16'h0000));
    tick();
    check("t3_hold_instr2", instr, mem_word(16'h0000));
    stall = 1'b0;
    tick();
    check("t3_skid_valid", 16'(valid), 16'd1);
    check("t3_skid_instr", instr, mem_word(16'h0002));
    check("t3_skid_pcp2", pc_plus2, 16'h0004);
    tick();
    tick();
    end_test("t3_drained");

    // Redirect with a request in flight
    lat = 3;
    push(16'h0040);
    release_rst();
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("t4_drain_req", 16'(imem_req), 16'd1);
    check("t4_drain_addr", imem_addr, 16'h0000);
    check("t4_flush_valid", 16'(valid), 16'd0);
    tick();
    check("t4_new_addr", imem_addr, 16'h0040);
    repeat (3) tick();
    check("t4_valid", 16'(valid), 16'd1);
    check("t4_instr", instr, mem_word(16'h0040));
    check("t4_pcp2", pc_plus2, 16'h0042);
    tick();
    end_test("t4_drained");

    // Halt: quiet until reset
    lat = 1;
    push(16'h0000);
    release_rst();
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t5_valid", 16'(valid), 16'd0);
    check("t5_instr", instr, NOP);
    check("t5_req", 16'(imem_req), 16'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t5_quiet_req", 16'(imem_req), 16'd0);
      check("t5_quiet_valid", 16'(valid), 16'd0);
    end
    end_test("t5_drained");

    // Odd redirect target
    lat = 1;
    push(16'h0000);
    release_rst();
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0041;
    tick();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("t6_err", 16'(err), 16'd1);
    check("t6_req", 16'(imem_req), 16'd0);
    check("t6_valid", 16'(valid), 16'd0);
    repeat (3) tick();
    check("t6_err_sticky", 16'(err), 16'd1);
    check("t6_req_quiet", 16'(imem_req), 16'd0);
`else
    push(16'h0040);
    check("t6_err", 16'(err), 16'd0);
    check("t6_req", 16'(imem_req), 16'd1);
    check("t6_addr", imem_addr, 16'h0040);
    tick();
    check("t6_valid", 16'(valid), 16'd1);
    check("t6_instr", instr, mem_word(16'h0040));
    tick();
`endif
    end_test("t6_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
